// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply issue/writeback controller.
package mul_pkg;

    // RV32M multiply flavours, encoded as funct3[1:0].
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // Controller states: waiting for an op, waiting on the multiplier,
    // holding a result for writeback.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    // Cycles from accept edge to out_valid on the multiplier path.
    localparam int MUL_LAT = 7;

    // True when either operand is zero, so every op flavour yields zero.
    function automatic logic has_zero_operand(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'd0) || (b == 32'd0);
    endfunction

endpackage

// File: rtl/mul_fixup.sv
// Result formation: selects the product word for the op and, for the
// high-word ops with unsigned operands, corrects the signed 64-bit product.
// Treating an unsigned operand x as signed loses x[31]*2^32, which shows up
// in the high word as a missing "other operand" term; adding it back mod 2^32
// turns the signed product's high word into the mixed/unsigned one.
module mul_fixup
    import mul_pkg::*;
(
    input  mul_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] prod_i,
    output logic [31:0] data_o
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] corr_b_unsigned;
    logic [31:0] corr_a_unsigned;

    assign hi = prod_i[63:32];
    assign lo = prod_i[31:0];

    // Correction term needed when b is reinterpreted as unsigned.
    assign corr_b_unsigned = b_i[31] ? a_i : 32'd0;
    // Correction term needed when a is reinterpreted as unsigned.
    assign corr_a_unsigned = a_i[31] ? b_i : 32'd0;

    // Pick/correct the product word for the requested flavour.
    always_comb begin
        data_o = lo;
        case (op_i)
            MUL:     data_o = lo;
            MULH:    data_o = hi;
            MULHSU:  data_o = hi + corr_b_unsigned;
            MULHU:   data_o = hi + corr_a_unsigned + corr_b_unsigned;
            default: data_o = lo;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the shared 32x32 signed pipelined multiplier.
// Accepts one RV32M multiply at a time, holds operands and a level request to
// the multiplier until its done pulse, corrects the high word for unsigned
// operands and presents the result with its tag over valid/ready.
// Zero operands optionally bypass the multiplier entirely.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,

    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_req,
    input  logic             mul_rdy,
    input  logic [63:0]      mul_r,

    output logic             busy
);

    mul_state_e       state_q,   state_d;
    mul_op_e          op_q,      op_d;
    logic [TAG_W-1:0] tag_q,     tag_d;
    logic [31:0]      mul_a_q,   mul_a_d;
    logic [31:0]      mul_b_q,   mul_b_d;
    logic             mul_req_q, mul_req_d;
    logic [31:0]      data_q,    data_d;
    // Set when a flush lands while the multiplier is working; the product is
    // still drained (dropping req early would confuse the multiplier) but
    // thrown away.
    logic             kill_q,    kill_d;
    // Sticky flag: multiplier signalled done while nobody was waiting for it.
    logic             rdy_err_q, rdy_err_d;

    logic             accept;
    logic             zero_hit;
    logic [31:0]      fixed_result;

    // Result correction works on the held operands, which are exactly what
    // the multiplier has been multiplying.
    mul_fixup u_fixup (
        .op_i   (op_q),
        .a_i    (mul_a_q),
        .b_i    (mul_b_q),
        .prod_i (mul_r),
        .data_o (fixed_result)
    );

    // flush wins over a same-cycle request, so a flushed op is never taken.
    assign accept   = (state_q == IDLE) && in_valid && !flush;
    assign zero_hit = ZERO_BYPASS && has_zero_operand(in_rs1, in_rs2);

    // Next-state and datapath-register update for the issue FSM.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_req_d = mul_req_q;
        data_d    = data_q;
        kill_d    = kill_q;
        rdy_err_d = rdy_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = mul_op_e'(in_op);
                    tag_d   = in_tag;
                    mul_a_d = in_rs1;
                    mul_b_d = in_rs2;
                    kill_d  = 1'b0;
                    if (zero_hit) begin
                        data_d  = 32'd0;
                        state_d = DONE;
                    end else begin
                        mul_req_d = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end

            BUSY: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mul_rdy) begin
                    // req must fall on the very edge that sees rdy, otherwise
                    // the multiplier starts counting a new request.
                    mul_req_d = 1'b0;
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        data_d  = fixed_result;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                mul_req_d = 1'b0;
            end
        endcase

        if (mul_rdy && (state_q != BUSY)) begin
            rdy_err_d = 1'b1;
        end
    end

    // State and datapath registers; everything clears as soon as rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            tag_q     <= '0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            mul_req_q <= 1'b0;
            data_q    <= 32'd0;
            kill_q    <= 1'b0;
            rdy_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_req_q <= mul_req_d;
            data_q    <= data_d;
            kill_q    <= kill_d;
            rdy_err_q <= rdy_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    // A flush in DONE withdraws the result in the same cycle, so writeback
    // never sees a handshake on a discarded op.
    assign out_valid = (state_q == DONE) && !flush;
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_req   = mul_req_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomised bench for mul_issue_ctrl with a behavioural multiplier and a
// reference model that computes results straight from 64-bit arithmetic.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [31:0]      in_rs1 = 32'd0;
    logic [31:0]      in_rs2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_req;
    logic             mul_rdy;
    logic [63:0]      mul_r;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.ZERO_BYPASS(1'b1), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_req   (mul_req),
        .mul_rdy   (mul_rdy),
        .mul_r     (mul_r),
        .busy      (busy)
    );

    // Multiplier model: rdy pulses after the 6th edge that sees req high;
    // keeping req high past that edge starts a new count.
    int unsigned      mcnt;
    logic signed [63:0] pa, pb;
    assign pa = {{32{mul_a[31]}}, mul_a};
    assign pb = {{32{mul_b[31]}}, mul_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt    <= 0;
            mul_rdy <= 1'b0;
            mul_r   <= 64'd0;
        end else begin
            mul_rdy <= 1'b0;
            if (!mul_req) begin
                mcnt <= 0;
            end else begin
                mcnt <= (mcnt == 6) ? 1 : mcnt + 1;
                if (mcnt == 5) begin
                    mul_rdy <= 1'b1;
                    mul_r   <= pa * pb;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from full-width products of extended operands.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, su;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        su = ub;
        case (op)
            2'd0:    begin p = ua * ub; return p[31:0];  end
            2'd1:    begin p = sa * sb; return p[63:32]; end
            2'd2:    begin p = sa * su; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    // One full transaction: accept, wait for result, stall writeback for
    // 'hold' cycles, then complete the handshake.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int hold);
        logic [31:0] exp;
        bit byp;
        int lat;
        int reqs;
        exp = ref_result(op, a, b);
        byp = (a == 32'd0) || (b == 32'd0);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1 = $urandom;
        in_rs2 = $urandom;
        in_tag = TAG_W'($urandom);
        lat = 0;
        reqs = 0;
        while (!out_valid && lat < 20) begin
            if (mul_req) reqs++;
            if (lat == 3 && !byp) begin
                check("mul_a_held", mul_a, a);
                check("mul_b_held", mul_b, b);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, byp ? 0 : MUL_LAT);
        check("req_cycles", reqs, byp ? 0 : 7);
        for (int i = 0; i < hold; i++) begin
            check("hold_data", out_data, exp);
            check("hold_tag", out_tag, tag);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp);
        check("out_tag", out_tag, tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_wb", busy, 0);
        check("valid_after_wb", out_valid, 0);
        $display("op=%0d a=%08h b=%08h tag=%0d lat=%0d hold=%0d data=%08h exp=%08h",
                 op, a, b, tag, lat, hold, out_data, exp);
    endtask

    logic [31:0] ra, rb;

    initial begin
        // Reset state
        #2;
        check("rst_mul_req", mul_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mul_a", mul_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 1);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 2);
        run_op(2'd2, 32'd2, 32'h8000_0000, 5'd1, 0);
        run_op(2'd0, 32'd0, 32'h1234_5678, 5'd12, 0);
        run_op(2'd3, 32'h8000_0001, 32'h7FFF_FFFF, 5'd21, 5);

        // flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_rs1 = 32'd5; in_rs2 = 32'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_req", mul_req, 0);
        $display("flush in IDLE with in_valid: busy=%0d", busy);

        // flush 3 cycles into BUSY: drain, no result
        begin
            int reqs;
            bit seen;
            reqs = 0; seen = 0;
            @(negedge clk);
            in_valid = 1'b1; in_op = 2'd1; in_rs1 = 32'h1357_9BDF; in_rs2 = 32'h0246_8ACE;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int k = 0; k <= 10; k++) begin
                if (mul_req) reqs++;
                if (out_valid) seen = 1;
                if (k == 3) flush = 1'b1;
                if (k == 4) flush = 1'b0;
                @(posedge clk);
                #1;
            end
            check("flush_busy_reqs", reqs, 7);
            check("flush_busy_no_valid", seen, 0);
            check("flush_busy_idle", busy, 0);
            check("flush_busy_in_ready", in_ready, 1);
            $display("flush in BUSY: req cycles=%0d out_valid seen=%0d", reqs, seen);
        end

        // flush while DONE withdraws the result
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'd0; in_rs2 = 32'd44; in_tag = 5'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_valid", out_valid, 1);
        flush = 1'b1;
        #1;
        check("flush_done_valid", out_valid, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_idle", busy, 0);
        $display("flush in DONE: busy=%0d out_valid=%0d", busy, out_valid);

        // Reset in the middle of BUSY
        run_op(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd27, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1; in_rs1 = 32'h7654_3210; in_rs2 = 32'h89AB_CDEF; in_tag = 5'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", mul_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_a", mul_a, 0);
        check("mid_rst_b", mul_b, 0);
        $display("reset mid-BUSY: req=%0d busy=%0d data=%08h", mul_req, busy, out_data);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd1, 32'h7654_3210, 32'h89AB_CDEF, 5'd31, 0);

        // Randomised ops
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 5) == 0) ra = {1'b1, 31'd0};
            run_op(2'($urandom_range(0, 3)), ra, rb, TAG_W'($urandom), $urandom_range(0, 5));
        end

        check("no_stray_rdy", dut.rdy_err_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
